// File: rtl/fir_interp2x_mac_if.sv
// rtl/fir_interp2x_mac_if.sv - sample stream, output stream and coefficient ROM signals of the 2x interpolator
interface fir_interp2x_mac_if #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 16,
  parameter int TAPS   = 32
);
  localparam int ROM_AW = $clog2(2 * TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [ROM_AW-1:0]        rom_addr;
  logic signed [COEF_W-1:0] rom_data;

  // master is the engine: it drives the output stream and the ROM address
  modport master (
    input  in_valid, in_data, out_ready, rom_data,
    output in_ready, out_valid, out_data, rom_addr
  );

  modport slave (
    output in_valid, in_data, out_ready, rom_data,
    input  in_ready, out_valid, out_data, rom_addr
  );
endinterface

// File: rtl/fir_interp2x_mac.sv
// rtl/fir_interp2x_mac.sv - two-phase polyphase FIR interpolator with a one-tap-per-clock MAC
module fir_interp2x_mac #(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 32,
  parameter int COEF_FRAC = 15,
  parameter int ACC_W     = 45
) (
  input logic                clk,
  input logic                rst,
  fir_interp2x_mac_if.master io
);
  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {INIT, IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic [AW-1:0]            wp;
  logic [AW-1:0]            init_cnt;
  logic [AW-1:0]            k;
  logic                     phase;
  logic signed [ACC_W-1:0]  acc;

  logic signed [DATA_W-1:0] hist [TAPS];

  logic                     mem_we;
  logic [AW-1:0]            mem_waddr;
  logic signed [DATA_W-1:0] mem_wdata;
  logic [AW-1:0]            rd_idx;
  logic signed [DATA_W-1:0] x_k;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [DATA_W-1:0] sat_data;

  // single write port: zero fill during INIT, new sample on acceptance
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wp;
    mem_wdata = io.in_data;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = '0;
    end else if (state == IDLE && io.in_valid) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) hist[mem_waddr] <= mem_wdata;
  end

  assign rd_idx   = wp - AW'(1) - k;
  assign x_k      = hist[rd_idx];
  assign prod     = x_k * io.rom_data;
  assign acc_next = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign rounded  = (acc_next + HALF) >>> COEF_FRAC;

  always_comb begin
    sat_data = rounded[DATA_W-1:0];
    if (rounded > OUT_MAX)      sat_data = OUT_MAX[DATA_W-1:0];
    else if (rounded < OUT_MIN) sat_data = OUT_MIN[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      io.in_ready  <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.rom_addr  <= '0;
      acc          <= '0;
      wp           <= '0;
      init_cnt     <= '0;
      k            <= '0;
      phase        <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + AW'(1);
          if (init_cnt == AW'(TAPS - 1)) begin
            state       <= IDLE;
            io.in_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (io.in_valid) begin
            wp          <= wp + AW'(1);
            acc         <= '0;
            phase       <= 1'b0;
            k           <= '0;
            io.rom_addr <= '0;
            io.in_ready <= 1'b0;
            state       <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (k == AW'(TAPS - 1)) begin
            io.out_data  <= sat_data;
            io.out_valid <= 1'b1;
            state        <= OUT;
          end else begin
            k           <= k + AW'(1);
            io.rom_addr <= {phase, k + AW'(1)};
          end
        end
        OUT: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            if (!phase) begin
              acc         <= '0;
              phase       <= 1'b1;
              k           <= '0;
              io.rom_addr <= {1'b1, AW'(0)};
              state       <= MAC;
            end else begin
              io.in_ready <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_interp2x_mac.sv
// tb/tb_fir_interp2x_mac.sv - scoreboard bench for the 2x polyphase interpolator
`timescale 1ns/1ps
module tb_fir_interp2x_mac;
  localparam int DATA_W = 24;
  localparam int COEF_W = 16;
  localparam int TAPS   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_interp2x_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) bus ();

  fir_interp2x_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .COEF_FRAC(15), .ACC_W(45)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  logic signed [COEF_W-1:0] rom     [2*TAPS];
  logic signed [COEF_W-1:0] rom_imp [2*TAPS];
  assign bus.rom_data = rom[bus.rom_addr];

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     rdy_mode = 0;
  int     last_accept = 0;
  longint exp_q [$];
  longint got_q [$];
  longint hist  [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // y_p[n] = sat(round(sum_k x[n-k] * c[p*TAPS+k] / 2^15)), history starts at zero
  function automatic longint model_out(input int ph);
    longint acc = 0;
    for (int j = 0; j < TAPS; j++)
      if (j < hist.size()) acc += hist[j] * longint'(rom[ph*TAPS + j]);
    acc = (acc + 16384) >>> 15;
    if (acc > 8388607)  acc = 8388607;
    if (acc < -8388608) acc = -8388608;
    return acc;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_q.push_back(longint'(bus.out_data));
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else                   chk("out_sample", longint'(bus.out_data), exp_q.pop_front());
    end
  end

  task automatic send(input longint x);
    bit done = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = x[DATA_W-1:0];
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done        = 1;
        last_accept = cyc;
        hist.push_front(x);
        if (hist.size() > TAPS) void'(hist.pop_back());
        exp_q.push_back(model_out(0));
        exp_q.push_back(model_out(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
    end
    if (!done) begin
      chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    int n = 0;
    bit ov_seen = 0;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready",  longint'(bus.in_ready), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data",  longint'(bus.out_data), 0);
    chk("rst_rom_addr",  longint'(bus.rom_addr), 0);
    exp_q.delete();
    hist.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.out_valid) ov_seen = 1;
      if (bus.in_ready) break;
    end
    chk("init_cycles", n, 32);
    chk("init_out_valid", ov_seen, 0);
  endtask

  task automatic impulse_run(input string tag);
    rdy_mode = 0;
    got_q.delete();
    send(32768);
    for (int i = 1; i < TAPS; i++) send(0);
    drain();
    chk({tag, "_count"}, got_q.size(), 64);
    if (got_q.size() == 64) begin
      chk({tag, "_p0_ph0"},  got_q[0],  -2);
      chk({tag, "_p0_ph1"},  got_q[1],  23);
      chk({tag, "_p15_ph0"}, got_q[30], 27489);
      chk({tag, "_p15_ph1"}, got_q[31], 11503);
      chk({tag, "_p31_ph0"}, got_q[62], 23);
      chk({tag, "_p31_ph1"}, got_q[63], -2);
    end
  endtask

  initial begin
    int t0, t1, t2, t3, bad_d, bad_v, bad_r, bad_a, hold_a, seen;
    longint hold_d;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 2*TAPS; i++) rom_imp[i] = COEF_W'($urandom_range(0, 4000)) - 16'sd2000;
    rom_imp[0] = -2;  rom_imp[TAPS]      = 23;
    rom_imp[15] = 27489; rom_imp[TAPS+15] = 11503;
    rom_imp[31] = 23; rom_imp[TAPS+31]   = -2;
    rom = rom_imp;

    #2;
    do_reset();
    impulse_run("impulse");

    // latency with out_ready held high
    rdy_mode = 0;
    send(longint'($urandom_range(0, 200000)) - 100000);
    t0 = last_accept; t1 = -1; t2 = -1; t3 = -1;
    for (int i = 0; i < 300 && t3 < 0; i++) begin
      @(negedge clk);
      if (bus.out_valid && t1 < 0) t1 = cyc;
      else if (bus.out_valid && t1 >= 0 && cyc > t1 + 1 && t2 < 0) t2 = cyc;
      if (bus.in_ready && t2 >= 0 && t3 < 0) t3 = cyc;
    end
    chk("lat_phase0", t1 - t0, 33);
    chk("lat_phase1", t2 - t0, 66);
    chk("lat_in_ready", t3 - t0, 67);
    drain();

    // backpressure in phase-0 OUT
    rdy_mode = 2;
    send(longint'($urandom_range(0, 4000000)) - 2000000);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("bp_out_valid_seen", seen, 1);
    hold_d = longint'(bus.out_data);
    hold_a = int'(bus.rom_addr);
    chk("bp_rom_addr_last_tap", hold_a, 31);
    bad_d = 0; bad_v = 0; bad_r = 0; bad_a = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (longint'(bus.out_data) != hold_d) bad_d++;
      if (!bus.out_valid) bad_v++;
      if (bus.in_ready) bad_r++;
      if (int'(bus.rom_addr) != hold_a) bad_a++;
    end
    chk("bp_data_stable", bad_d, 0);
    chk("bp_valid_held", bad_v, 0);
    chk("bp_in_ready_low", bad_r, 0);
    chk("bp_rom_addr_stable", bad_a, 0);
    rdy_mode = 0;
    drain();

    // saturation with a ROM of all 32767
    for (int i = 0; i < 2*TAPS; i++) rom[i] = 16'sd32767;
    rdy_mode = 1;
    got_q.delete();
    for (int i = 0; i < TAPS; i++) send(-8388608);
    for (int i = 0; i < TAPS; i++) send(8388607);
    drain();
    chk("sat_count", got_q.size(), 128);
    if (got_q.size() == 128) begin
      chk("sat_neg_ph0", got_q[62], -8388608);
      chk("sat_neg_ph1", got_q[63], -8388608);
      chk("sat_pos_ph0", got_q[126], 8388607);
      chk("sat_pos_ph1", got_q[127], 8388607);
    end

    // random coefficients and samples under random backpressure
    for (int i = 0; i < 2*TAPS; i++) rom[i] = COEF_W'($urandom);
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       send(-8388608);
        1:       send(8388607);
        default: send(longint'($urandom_range(0, 16777215)) - 8388608);
      endcase
    end
    drain();

    // reset in phase 1 at k=10, then a clean impulse
    rom = rom_imp;
    rdy_mode = 0;
    send(longint'($urandom_range(0, 16777215)) - 8388608);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.rom_addr == 6'd42) seen = 1;
    end
    chk("midmac_reached", seen, 1);
    do_reset();
    impulse_run("impulse_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
